// File: rtl/loa_cla_pkg.sv
// Shared types and helpers for the key-locked pipelined LOA adder.
// Key-load states, the per-block stage-1 payload and the 4-bit group generate/propagate.
package loa_cla_pkg;

  localparam int KEY_SEG = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } key_state_e;

  // One upper-part CLA block as captured in stage 1.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       g;
    logic       p;
    logic       dkey_c;
  } s1_blk_t;

  function automatic int nblk(input int width, input int lower);
    return (width - lower) / 4;
  endfunction

  // Group generate/propagate of a 4-bit slice, returned as {g, p}.
  function automatic logic [1:0] blk_gp(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] g_v;
    logic [3:0] p_v;
    logic       grp_g;
    logic       grp_p;
    g_v   = a & b;
    p_v   = a ^ b;
    grp_g = g_v[3]
          | (p_v[3] & g_v[2])
          | (p_v[3] & p_v[2] & g_v[1])
          | (p_v[3] & p_v[2] & p_v[1] & g_v[0]);
    grp_p = &p_v;
    return {grp_g, grp_p};
  endfunction

endpackage

// File: rtl/loa_cla_adder_pipe_locked_block.sv
// 4-bit carry-lookahead block whose carry-in is gated by one key-difference bit.
// A correct key (dkey_c = 0) makes this a plain 4-bit CLA.
module loa_cla_block (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       dkey_c,
  output logic [3:0] sum,
  output logic       g,
  output logic       p,
  output logic       cout
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic       w_c0;
  logic [4:1] w_c;

  assign w_g  = a & b;
  assign w_p  = a ^ b;
  assign w_c0 = cin ^ dkey_c;

  assign w_c[1] = w_g[0] | (w_p[0] & w_c0);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c0);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c0);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c0);

  assign sum  = w_p ^ {w_c[3:1], w_c0};
  assign g    = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign p    = &w_p;
  assign cout = w_c[4];

endmodule

// File: rtl/loa_cla_adder_pipe_locked.sv
// Two-stage key-locked lower-part-OR adder with valid/ready handshake and multi-word key load.
// Optional completed-output counter on op_cnt_o when LOA_OP_CNT_EN is defined.
module loa_cla_adder_pipe_locked
  import loa_cla_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               LOWER       = 8,
  parameter int               KEY_W       = 64,
  parameter logic [KEY_W-1:0] CORRECT_KEY = 64'hA5C3_0F96_5A3C_F069
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o,
  input  logic             key_valid_i,
  input  logic [31:0]      key_data_i,
  output logic             key_busy_o
`ifdef LOA_OP_CNT_EN
  ,
  output logic [31:0]      op_cnt_o
`endif
);

  localparam int NBLK   = nblk(WIDTH, LOWER);
  localparam int DU     = NBLK + WIDTH + 1;
  localparam int NWORDS = KEY_W / KEY_SEG;
  localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  key_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_shadow;
  logic [KEY_W-1:0] r_active;
  logic             r_key_busy;
  logic [KEY_W-1:0] w_shadow_nxt;

  logic             r_s1_valid;
  logic [LOWER-1:0] r_s1_lower;
  logic             r_s1_cin;
  logic [WIDTH:0]   r_s1_dout;
  s1_blk_t          r_s1_blk [NBLK];

  logic             r_out_valid;
  logic [WIDTH:0]   r_result;

  logic             w_adv2;
  logic             w_s1_en;
  logic             w_acc;
  logic [DU-1:0]    w_d;
  logic [1:0]       w_gp [NBLK];
  logic [NBLK-1:0]  w_c;
  logic             w_cout;
  logic [4*NBLK-1:0] w_blk_sum;
  logic [NBLK-1:0]  w_blk_g;
  logic [NBLK-1:0]  w_blk_p;
  logic [NBLK-1:0]  w_blk_cout;
  logic             w_blk_unused;
  logic [WIDTH:0]   w_res;

  // Whole-pipe stall: stage 1 may refill when empty or when stage 2 moves on.
  assign w_adv2     = ~r_out_valid | out_ready_i;
  assign w_s1_en    = ~r_s1_valid | w_adv2;
  assign in_ready_o = (r_state != LOAD) & w_s1_en;
  assign w_acc      = in_valid_i & in_ready_o;

  // Only the carry-gate and result-gate bits of the key difference are kept.
  assign w_d = r_active[DU-1:0] ^ CORRECT_KEY[DU-1:0];

  if (KEY_W > DU) begin : g_key_spare
    logic w_key_unused;
    assign w_key_unused = ^r_active[KEY_W-1:DU];
  end

  // Shadow key with the incoming word placed at the current word slot.
  always_comb begin
    w_shadow_nxt = r_shadow;
    w_shadow_nxt[KEY_SEG*int'(r_cnt) +: KEY_SEG] = key_data_i;
  end

  // Key-load FSM; the whole key becomes active on the edge that stores the last word.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_shadow   <= '0;
      r_active   <= '0;
      r_key_busy <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RUN: begin
          if (key_valid_i) begin
            r_shadow <= w_shadow_nxt;
            if (NWORDS == 1) begin
              r_active   <= w_shadow_nxt;
              r_state    <= RUN;
              r_key_busy <= 1'b0;
            end else begin
              r_cnt      <= CNT_W'(1);
              r_state    <= LOAD;
              r_key_busy <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (key_valid_i) begin
            r_shadow <= w_shadow_nxt;
            if (r_cnt == CNT_W'(NWORDS - 1)) begin
              r_active   <= w_shadow_nxt;
              r_cnt      <= '0;
              r_state    <= RUN;
              r_key_busy <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_cnt      <= '0;
          r_key_busy <= 1'b0;
        end
      endcase
    end
  end

  // Per-block generate/propagate of the incoming upper operands.
  always_comb begin
    for (int b = 0; b < NBLK; b++) begin
      w_gp[b] = blk_gp(add1_i[LOWER+4*b +: 4], add2_i[LOWER+4*b +: 4]);
    end
  end

  // Stage 1: approximate low part, low carry, block G/P, upper operands and key gates.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0;
      r_s1_lower <= '0;
      r_s1_cin   <= 1'b0;
      r_s1_dout  <= '0;
      for (int b = 0; b < NBLK; b++) begin
        r_s1_blk[b] <= '0;
      end
    end else if (w_s1_en) begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_s1_lower <= add1_i[LOWER-1:0] | add2_i[LOWER-1:0];
        r_s1_cin   <= add1_i[LOWER-1] & add2_i[LOWER-1];
        r_s1_dout  <= w_d[DU-1:NBLK];
        for (int b = 0; b < NBLK; b++) begin
          r_s1_blk[b].a      <= add1_i[LOWER+4*b +: 4];
          r_s1_blk[b].b      <= add2_i[LOWER+4*b +: 4];
          r_s1_blk[b].g      <= w_gp[b][1];
          r_s1_blk[b].p      <= w_gp[b][0];
          r_s1_blk[b].dkey_c <= w_d[b];
        end
      end
    end
  end

  // Block carry-in lookahead from stage-1 G/P; each carry is key-gated before use.
  always_comb begin
    logic c_v;
    c_v = r_s1_cin;
    for (int b = 0; b < NBLK; b++) begin
      w_c[b] = c_v;
      c_v    = r_s1_blk[b].g | (r_s1_blk[b].p & (c_v ^ r_s1_blk[b].dkey_c));
    end
    w_cout = c_v;
  end

  for (genvar b = 0; b < NBLK; b++) begin : g_blk
    loa_cla_block u_blk (
      .a      (r_s1_blk[b].a),
      .b      (r_s1_blk[b].b),
      .cin    (w_c[b]),
      .dkey_c (r_s1_blk[b].dkey_c),
      .sum    (w_blk_sum[4*b +: 4]),
      .g      (w_blk_g[b]),
      .p      (w_blk_p[b]),
      .cout   (w_blk_cout[b])
    );
  end

  assign w_blk_unused = ^{w_blk_g, w_blk_p, w_blk_cout};
  assign w_res        = {w_cout, w_blk_sum, r_s1_lower} ^ r_s1_dout;

  // Stage 2: registered result, held while the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_res;
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign result_o    = r_result;
  assign key_busy_o  = r_key_busy;

`ifdef LOA_OP_CNT_EN
  logic [31:0] r_op_cnt;

  // Saturating count of delivered results.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_op_cnt <= 32'd0;
    end else if (r_out_valid && out_ready_i && (r_op_cnt != 32'hFFFF_FFFF)) begin
      r_op_cnt <= r_op_cnt + 32'd1;
    end
  end

  assign op_cnt_o = r_op_cnt;
`endif

endmodule
